// File: rtl/imem_fetch.sv
// Instruction store with a single-entry registered fetch response, valid/ready
// handshaking on both sides, a run-time program-load port and fault codes.
module imem_fetch #(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_instr,
  output logic [1:0]            resp_fault,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic [31:0]           fetch_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  typedef enum logic {
    RESP_EMPTY,
    RESP_FULL
  } resp_state_e;

  resp_state_e state_q, state_d;

  // Contents survive reset; only the declaration fill sets them at power-up.
  logic [31:0] mem_q [DEPTH] = '{default: NOP_WORD};

  logic [31:0]           instr_q;
  logic [1:0]            fault_q, fault_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d;
  logic                  accept;
  logic                  deliver;
  logic                  misaligned;
  logic                  out_of_range;
  logic [DEPTH_LOG2-1:0] word_idx;

  assign word_idx     = req_addr[DEPTH_LOG2+1:2];
  assign misaligned   = |req_addr[1:0];
  assign out_of_range = |req_addr[31:DEPTH_LOG2+2];

  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    fetch_cnt_d = fetch_cnt_q;

    req_ready = !flush && !ld_en && ((state_q == RESP_EMPTY) || resp_ready);
    accept    = req_valid && req_ready;
    // A flushed response is discarded, never counted as delivered.
    deliver   = (state_q == RESP_FULL) && resp_ready && !flush;

    if (deliver) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end

    if (flush) begin
      state_d = RESP_EMPTY;
    end else if (accept) begin
      state_d = RESP_FULL;
    end else if (deliver) begin
      state_d = RESP_EMPTY;
    end

    if (accept) begin
      if (misaligned) begin
        fault_d = FAULT_MISALIGN;
      end else if (out_of_range) begin
        fault_d = FAULT_RANGE;
      end else begin
        fault_d = FAULT_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RESP_EMPTY;
      fault_q     <= FAULT_NONE;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Registered read port; a faulting fetch never touches the array.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
    end else if (accept) begin
      instr_q <= (misaligned || out_of_range) ? NOP_WORD : mem_q[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  assign resp_valid = (state_q == RESP_FULL);
  assign resp_instr = instr_q;
  assign resp_fault = fault_q;
  assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Self-checking bench for imem_fetch: vector table, directed corner sequences
// and a randomized run against a transaction-level reference model.
module tb_imem_fetch;

  localparam int unsigned DL2   = 8;
  localparam int unsigned WORDS = 1 << DL2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [1:0]  resp_fault;
  logic        flush;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] fetch_cnt;

  imem_fetch #(.DEPTH_LOG2(DL2), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_fault (resp_fault),
    .flush      (flush),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .fetch_cnt  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the memory image plus the one outstanding response.
  logic [31:0] mdl_mem [WORDS];
  logic        mdl_valid;
  logic [31:0] mdl_instr;
  logic [1:0]  mdl_fault;
  logic [31:0] mdl_cnt;
  logic        last_rdy;

  typedef struct {
    logic        rv;
    logic [31:0] addr;
    logic        rr;
    logic        fl;
    logic        ld;
    logic [7:0]  la;
    logic [31:0] ld_d;
    logic        exp_rdy;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [1:0]  exp_fault;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // What a fetch of byte address a must return, straight from the address rules.
  function automatic logic [33:0] expect_fetch(input logic [31:0] a);
    if ((a % 4) != 0) return {2'b01, NOP};
    if (a >= 4 * WORDS) return {2'b10, NOP};
    return {2'b00, mdl_mem[a / 4]};
  endfunction

  task automatic drive_cycle(input logic rst, input logic rv, input logic [31:0] addr,
                             input logic rr, input logic fl, input logic ld,
                             input logic [7:0] la, input logic [31:0] ld_d);
    logic        m_rdy, acc, del;
    logic [33:0] resp;
    rst_n = rst; req_valid = rv; req_addr = addr; resp_ready = rr;
    flush = fl; ld_en = ld; ld_addr = la; ld_data = ld_d;
    #1;
    m_rdy = !fl && !ld && (!mdl_valid || rr);
    acc   = rv && m_rdy;
    del   = mdl_valid && rr && !fl;
    resp  = expect_fetch(addr);
    last_rdy = req_ready;
    chk("req_ready", req_ready, m_rdy);
    @(posedge clk);
    #1;
    if (!rst) begin
      mdl_valid = 1'b0; mdl_instr = NOP; mdl_fault = 2'b00; mdl_cnt = 32'd0;
    end else begin
      if (del) begin
        mdl_cnt = mdl_cnt + 32'd1;
        $display("deliver cnt=%0d instr=%h fault=%0d", mdl_cnt, mdl_instr, mdl_fault);
      end
      if (ld) mdl_mem[la] = ld_d;
      if (fl) mdl_valid = 1'b0;
      else if (acc) begin
        mdl_valid = 1'b1;
        mdl_fault = resp[33:32];
        mdl_instr = resp[31:0];
      end else if (del) mdl_valid = 1'b0;
    end
    chk("resp_valid", resp_valid, mdl_valid);
    if (mdl_valid) begin
      chk("resp_instr", resp_instr, mdl_instr);
      chk("resp_fault", resp_fault, mdl_fault);
    end
    chk("fetch_cnt", fetch_cnt, mdl_cnt);
  endtask

  task automatic idle(input logic rr);
    drive_cycle(1'b1, 1'b0, 32'h0, rr, 1'b0, 1'b0, 8'd0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    drive_cycle(1'b1, 1'b1, a, rr, 1'b0, 1'b0, 8'd0, 32'h0);
  endtask

  initial begin
    int          r;
    logic        rv, rr, fl, ld;
    logic [31:0] a;

    for (int i = 0; i < WORDS; i++) mdl_mem[i] = NOP;
    mdl_valid = 1'b0; mdl_instr = NOP; mdl_fault = 2'b00; mdl_cnt = 32'd0;

    // Reset
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    drive_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 8'd0, 32'h0);
    chk("rst_valid", resp_valid, 1'b0);
    chk("rst_instr", resp_instr, NOP);
    chk("rst_fault", resp_fault, 2'b00);
    chk("rst_cnt", fetch_cnt, 32'd0);
    idle(1'b1);
    chk("rst_ready", last_rdy, 1'b1);

    // rv addr rr fl ld la ld_d | rdy valid instr fault cnt
    vq.push_back('{1'b1, 32'h0,  1'b1, 1'b0, 1'b1, 8'd0, 32'h0040_0093, 1'b0, 1'b0, NOP, 2'd0, 32'd0});
    vq.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 8'd1, 32'h0060_0113, 1'b0, 1'b0, NOP, 2'd0, 32'd0});
    vq.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 8'd2, 32'h0020_81B3, 1'b0, 1'b0, NOP, 2'd0, 32'd0});
    vq.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 8'd3, 32'h0221_8233, 1'b0, 1'b0, NOP, 2'd0, 32'd0});
    vq.push_back('{1'b1, 32'h0,  1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b1, 32'h0040_0093, 2'd0, 32'd0});
    vq.push_back('{1'b1, 32'h4,  1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b1, 32'h0060_0113, 2'd0, 32'd1});
    vq.push_back('{1'b1, 32'h8,  1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b1, 32'h0020_81B3, 2'd0, 32'd2});
    vq.push_back('{1'b1, 32'hC,  1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b1, 32'h0221_8233, 2'd0, 32'd3});
    vq.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, NOP, 2'd0, 32'd4});
    vq.push_back('{1'b1, 32'h6,  1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b1, NOP, 2'd1, 32'd4});
    vq.push_back('{1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b1, NOP, 2'd2, 32'd5});
    vq.push_back('{1'b1, 32'h402, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b1, NOP, 2'd1, 32'd6});
    vq.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, NOP, 2'd0, 32'd7});
    vq.push_back('{1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 8'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, NOP, 2'd0, 32'd7});
    vq.push_back('{1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'd0, 32'd7});
    vq.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, NOP, 2'd0, 32'd8});
    vq.push_back('{1'b1, 32'h8000_0003, 1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b1, NOP, 2'd1, 32'd8});
    vq.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 8'd0, 32'h0, 1'b1, 1'b0, NOP, 2'd0, 32'd9});

    for (int i = 0; i < vq.size(); i++) begin
      drive_cycle(1'b1, vq[i].rv, vq[i].addr, vq[i].rr, vq[i].fl, vq[i].ld, vq[i].la, vq[i].ld_d);
      chk($sformatf("v%0d_rdy", i), last_rdy, vq[i].exp_rdy);
      chk($sformatf("v%0d_valid", i), resp_valid, vq[i].exp_valid);
      if (vq[i].exp_valid) begin
        chk($sformatf("v%0d_instr", i), resp_instr, vq[i].exp_instr);
        chk($sformatf("v%0d_fault", i), resp_fault, vq[i].exp_fault);
      end
      chk($sformatf("v%0d_cnt", i), fetch_cnt, vq[i].exp_cnt);
      $display("vec %0d addr=%h valid=%0d instr=%h fault=%0d cnt=%0d",
               i, vq[i].addr, resp_valid, resp_instr, resp_fault, fetch_cnt);
    end

    // Backpressure hold, then back-to-back delivery plus accept
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 8'd4, 32'h1111_1111);
    fetch(32'h10, 1'b0);
    chk("hold_first", resp_instr, 32'h1111_1111);
    for (int k = 0; k < 3; k++) begin
      fetch(32'h14, 1'b0);
      chk("hold_rdy", last_rdy, 1'b0);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_instr", resp_instr, 32'h1111_1111);
      chk("hold_cnt", fetch_cnt, 32'd9);
    end
    fetch(32'h14, 1'b1);
    chk("b2b_rdy", last_rdy, 1'b1);
    chk("b2b_instr", resp_instr, 32'hDEAD_BEEF);
    chk("b2b_cnt", fetch_cnt, 32'd10);

    // Flush of a held response
    fetch(32'h0, 1'b0);
    drive_cycle(1'b1, 1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 8'd0, 32'h0);
    chk("flush_rdy", last_rdy, 1'b0);
    chk("flush_valid", resp_valid, 1'b0);
    chk("flush_cnt", fetch_cnt, 32'd10);
    idle(1'b1);
    chk("flush_noacc", resp_valid, 1'b0);

    // Load together with flush
    fetch(32'h0, 1'b0);
    drive_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 8'd6, 32'hCAFE_F00D);
    chk("ldfl_valid", resp_valid, 1'b0);
    chk("ldfl_cnt", fetch_cnt, 32'd10);
    fetch(32'h18, 1'b1);
    chk("ldfl_instr", resp_instr, 32'hCAFE_F00D);
    idle(1'b1);
    chk("ldfl_cnt2", fetch_cnt, 32'd11);

    // Counter wrap via backdoor preload
    force dut.fetch_cnt_d = 32'hFFFF_FFFF;
    mdl_cnt = 32'hFFFF_FFFF;
    idle(1'b1);
    release dut.fetch_cnt_d;
    chk("wrap_pre", fetch_cnt, 32'hFFFF_FFFF);
    fetch(32'h0, 1'b1);
    idle(1'b1);
    chk("wrap_zero", fetch_cnt, 32'd0);

    // Reset during a held response, with a load that must be ignored
    fetch(32'h4, 1'b0);
    drive_cycle(1'b0, 1'b1, 32'h8, 1'b0, 1'b0, 1'b1, 8'd0, 32'hBAD0_BAD0);
    chk("rsth_valid", resp_valid, 1'b0);
    chk("rsth_instr", resp_instr, NOP);
    chk("rsth_fault", resp_fault, 2'b00);
    chk("rsth_cnt", fetch_cnt, 32'd0);
    fetch(32'h0, 1'b1);
    chk("rsth_mem0", resp_instr, 32'h0040_0093);
    fetch(32'h4, 1'b1);
    chk("rsth_mem1", resp_instr, 32'h0060_0113);
    chk("rsth_cnt1", fetch_cnt, 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 9));
      if (r == 0) a = $urandom();
      else if (r == 1) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 15) == 0);
      ld = ($urandom_range(0, 7) == 0);
      drive_cycle(1'b1, rv, a, rr, fl, ld, 8'($urandom_range(0, 255)), $urandom());
    end
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Parametrised, synchronous instruction memory with a valid/ready fetch port, a program-load write port, and fault reporting. It is the next generation of the core's combinational instruction ROM. It sits between the IF stage and the instruction store, giving one-cycle registered reads with backpressure and pipeline-flush support. Programs are loaded at run time instead of being fixed at elaboration.

## Interface
- DEPTH_LOG2, 8: memory holds 2^DEPTH_LOG2 32-bit words.
- NOP_WORD, 32'h00000013: fill value and the instruction returned on a fault.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request accepted when high with req_valid.
- req_addr  in  32  byte address (PC).
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_instr  out  32  fetched instruction.
- resp_fault  out  2  00 ok, 01 misaligned, 10 out of range; misaligned wins if both apply.
- flush  in  1  discard the held or in-flight response.
- ld_en  in  1  program-load write strobe.
- ld_addr  in  DEPTH_LOG2  word index to write.
- ld_data  in  32  word to write.
- fetch_cnt  out  32  count of delivered responses.

## Operation
- Storage: a 2^DEPTH_LOG2 x 32 array, filled with NOP_WORD at time zero. rst_n does not alter the contents.
- Request acceptance: req_ready = !flush && !ld_en && (!resp_valid || resp_ready). The request handshake is req_valid && req_ready.
- Word index is req_addr[DEPTH_LOG2+1:2].
- Misaligned: req_addr[1:0] != 0.
- Out of range: any of req_addr[31:DEPTH_LOG2+2] nonzero.
- Any fault: resp_instr = NOP_WORD and resp_fault carries the code. Memory is not read.
- Response register: a single entry. On an accepted request it loads instr/fault and sets resp_valid.
- Hold: while resp_valid && !resp_ready, the response holds all fields stable.
- Delivery: on resp_valid && resp_ready with no new accept, resp_valid clears.
- Back-to-back: delivery and a new accept in the same cycle replace the response with no bubble.
- Flush: at the next edge resp_valid clears. No request is accepted in a flush cycle, because req_ready is low.
- Load: on ld_en, mem[ld_addr] <= ld_data at the edge. Load takes priority over fetch, which is why req_ready is low. A response already registered keeps its old data.
- fetch_cnt: increments on each resp_valid && resp_ready, including faulted responses. It wraps from 0xFFFFFFFF to 0. A flush-discarded response is not counted.

## Timing
- Read latency is 1 cycle: a request accepted at edge N gives resp_valid and resp_instr from edge N onward, visible in cycle N+1.
- Throughput is 1 fetch per cycle when resp_ready is held high and neither ld_en nor flush is asserted.
- req_ready is combinational from flush, ld_en, resp_valid and resp_ready. It has no path from req_valid or req_addr.
- Reset, sampled at the clk edge with rst_n low:
  - resp_valid = 0, resp_instr = NOP_WORD, resp_fault = 00, fetch_cnt = 0.
  - Memory is unchanged.
  - Reset mid-hold drops the held response. A load asserted in the reset cycle is ignored.
- Simultaneous events:
  - flush with resp_ready and resp_valid: the response is not counted and resp_valid clears.
  - ld_en with flush: the write happens and resp_valid clears.
- Load to a word, then a fetch of the same word in the next cycle, returns the new data.

## Test plan
- Reset, then load words 0..3 with 0x00400093, 0x00600113, 0x002081B3, 0x02218233. Fetch addresses 0,4,8,12 back-to-back with resp_ready=1. Expect those words on 4 consecutive cycles starting 1 cycle after the first accept, and fetch_cnt=4.
- Fetch addr 0x10 with resp_ready=0 for 3 cycles. Expect resp_valid held, instr stable, req_ready=0. Raise resp_ready: delivery occurs, and a queued request at 0x14 is accepted in the same cycle.
- Fetch 0x6 -> resp_fault=01, instr=0x00000013. Fetch 0x400 (DEPTH_LOG2=8) -> fault=10. Fetch 0x402 -> fault=01. fetch_cnt counts all three.
- Assert ld_en with req_valid high -> req_ready=0 and the write lands. The next-cycle fetch of that word returns ld_data.
- Hold a response with resp_ready=0, then pulse flush. Expect resp_valid=0 next cycle, fetch_cnt unchanged, and no request accepted in the flush cycle.
- Force fetch_cnt to 0xFFFFFFFF via 2^32 deliveries (or a bench backdoor), deliver one more -> 0. Assert rst_n=0 during a held response -> all outputs at reset values and memory contents preserved.
